// File: rtl/imm_ext_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_ext_pipe
// Purpose  : Registered immediate extender for the decode/execute boundary.
//            Decodes the immediate from the raw instruction word under a
//            one-hot format select, sign-extends it to XLEN, and precomputes
//            pc + imm. A valid/ready handshake with a two-entry skid buffer
//            keeps in_ready registered without losing beats on backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module imm_ext_pipe #(
  parameter int XLEN = 32,
  // Shift-amount width follows XLEN; not meant to be overridden.
  parameter int SHW  = (XLEN == 64) ? 6 : 5
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [5:0]      ext_op,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] tgt,
  output logic            op_err
);

  // One-hot format selects.
  localparam logic [5:0] C_OP_SHAMT = 6'b100000;
  localparam logic [5:0] C_OP_I     = 6'b010000;
  localparam logic [5:0] C_OP_S     = 6'b001000;
  localparam logic [5:0] C_OP_B     = 6'b000100;
  localparam logic [5:0] C_OP_U     = 6'b000010;
  localparam logic [5:0] C_OP_J     = 6'b000001;

  // Input-side combinational results.
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_tgt;
  logic            w_err;
  logic            w_accept;
  logic            w_drain;

  // The opcode field never carries immediate bits.
  logic            w_unused_opcode;
  assign w_unused_opcode = ^instr[6:0];

  // Output entry and skid entry state.
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_imm_q,   out_imm_d;
  logic [XLEN-1:0] out_tgt_q,   out_tgt_d;
  logic            out_err_q,   out_err_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_imm_q,   skid_imm_d;
  logic [XLEN-1:0] skid_tgt_q,   skid_tgt_d;
  logic            skid_err_q,   skid_err_d;
  logic            in_ready_q,   in_ready_d;

  // Decode the immediate for the selected format; anything not exactly
  // one-hot yields zero, and more than one bit set is flagged.
  always_comb begin
    w_imm = '0;
    w_err = (ext_op & (ext_op - 6'd1)) != 6'd0;
    case (ext_op)
      C_OP_SHAMT: w_imm = XLEN'(instr[20 +: SHW]);
      C_OP_I:     w_imm = XLEN'($signed(instr[31:20]));
      C_OP_S:     w_imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      C_OP_B:     w_imm = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                          instr[11:8], 1'b0}));
      C_OP_U:     w_imm = XLEN'($signed({instr[31:12], 12'b0}));
      C_OP_J:     w_imm = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                          instr[30:21], 1'b0}));
      default:    w_imm = '0;
    endcase
  end

  // Target is formed regardless of format; overflow simply wraps.
  assign w_tgt    = pc + w_imm;
  assign w_accept = in_valid && in_ready_q;
  assign w_drain  = out_valid_q && out_ready;

  // Next-state for the two entries: SKID always refills OUT first so the
  // older beat leaves before any newer one.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_tgt_d    = out_tgt_q;
    out_err_d    = out_err_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_tgt_d   = skid_tgt_q;
    skid_err_d   = skid_err_q;

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || w_drain) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_tgt_d    = skid_tgt_q;
        out_err_d    = skid_err_q;
        skid_valid_d = 1'b0;
      end else if (w_accept) begin
        out_valid_d  = 1'b1;
        out_imm_d    = w_imm;
        out_tgt_d    = w_tgt;
        out_err_d    = w_err;
      end else begin
        out_valid_d  = 1'b0;
      end
    end else if (w_accept) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = w_imm;
      skid_tgt_d   = w_tgt;
      skid_err_d   = w_err;
    end

    in_ready_d = !skid_valid_d;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_tgt_q    <= '0;
      out_err_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_tgt_q   <= '0;
      skid_err_q   <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_tgt_q    <= out_tgt_d;
      out_err_q    <= out_err_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_tgt_q   <= skid_tgt_d;
      skid_err_q   <= skid_err_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign imm       = out_imm_q;
  assign tgt       = out_tgt_q;
  assign op_err    = out_err_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_ext_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_ext_pipe
// Purpose  : Scoreboard bench for imm_ext_pipe at XLEN=32 and XLEN=64.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_ext_pipe;

  typedef struct {
    logic [63:0] imm;
    logic [63:0] tgt;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;

  logic        in_valid32 = 1'b0, in_ready32, out_valid32, out_ready32 = 1'b1;
  logic [31:0] instr32 = '0, pc32 = '0, imm32, tgt32;
  logic [5:0]  op32 = '0;
  logic        err32;

  logic        in_valid64 = 1'b0, in_ready64, out_valid64, out_ready64 = 1'b1;
  logic [31:0] instr64 = '0;
  logic [63:0] pc64 = '0, imm64, tgt64;
  logic [5:0]  op64 = '0;
  logic        err64;

  exp_t q32[$];
  exp_t q64[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  imm_ext_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid32), .in_ready(in_ready32),
    .instr(instr32), .ext_op(op32), .pc(pc32),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .imm(imm32), .tgt(tgt32), .op_err(err32)
  );

  imm_ext_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid64), .in_ready(in_ready64),
    .instr(instr64), .ext_op(op64), .pc(pc64),
    .out_valid(out_valid64), .out_ready(out_ready64),
    .imm(imm64), .tgt(tgt64), .op_err(err64)
  );

  // Scoreboard monitor, 32-bit instance: compare on every real output transfer.
  always @(negedge clk) begin
    if (rstn && !flush && out_valid32 && out_ready32) begin
      n_cmp++;
      if (q32.size() == 0) begin
        n_err++;
        $display("FAIL out32_unexpected: got imm=%h tgt=%h err=%0d, expected no beat",
                 imm32, tgt32, err32);
      end else begin
        exp_t e;
        e = q32.pop_front();
        if ({32'd0, imm32} !== e.imm || {32'd0, tgt32} !== e.tgt || err32 !== e.err) begin
          n_err++;
          $display("FAIL out32_beat: got imm=%h tgt=%h err=%0d, expected imm=%h tgt=%h err=%0d",
                   imm32, tgt32, err32, e.imm[31:0], e.tgt[31:0], e.err);
        end
      end
    end
  end

  // Scoreboard monitor, 64-bit instance.
  always @(negedge clk) begin
    if (rstn && !flush && out_valid64 && out_ready64) begin
      n_cmp++;
      if (q64.size() == 0) begin
        n_err++;
        $display("FAIL out64_unexpected: got imm=%h tgt=%h err=%0d, expected no beat",
                 imm64, tgt64, err64);
      end else begin
        exp_t e;
        e = q64.pop_front();
        if (imm64 !== e.imm || tgt64 !== e.tgt || err64 !== e.err) begin
          n_err++;
          $display("FAIL out64_beat: got imm=%h tgt=%h err=%0d, expected imm=%h tgt=%h err=%0d",
                   imm64, tgt64, err64, e.imm, e.tgt, e.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Offer one beat, wait (bounded) for acceptance, push its expectation.
  // Called and returns one time unit after a rising edge.
  task automatic send(input bit w64, input logic [31:0] ins, input logic [5:0] op,
                      input logic [63:0] p, input logic [63:0] e_imm,
                      input logic [63:0] e_tgt, input bit e_err);
    int   n;
    bit   acc;
    exp_t e;
    n   = 0;
    acc = 1'b0;
    e.imm = e_imm;
    e.tgt = e_tgt;
    e.err = e_err;
    if (w64) begin
      instr64 = ins; op64 = op; pc64 = p; in_valid64 = 1'b1;
    end else begin
      instr32 = ins; op32 = op; pc32 = p[31:0]; in_valid32 = 1'b1;
    end
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = w64 ? in_ready64 : in_ready32;
      if (acc) begin
        if (w64) q64.push_back(e);
        else     q32.push_back(e);
      end
      tick();
      n++;
    end
    in_valid32 = 1'b0;
    in_valid64 = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: instr=%h never accepted, expected acceptance", ins);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid32}, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready32},  64'd1);
    chk("rst_imm",       {32'd0, imm32},       64'd0);
    chk("rst_tgt",       {32'd0, tgt32},       64'd0);
    chk("rst_op_err",    {63'd0, err32},       64'd0);
    chk("rst_out_valid64", {63'd0, out_valid64}, 64'd0);
    rstn = 1'b1;
    tick();

    // addi x1,x0,-1 at pc 0x100; out_valid one cycle after accept.
    send(0, 32'hFFF00093, 6'b010000, 64'h100, 64'hFFFFFFFF, 64'h000000FF, 0);
    @(negedge clk);
    chk("latency_out_valid", {63'd0, out_valid32}, 64'd1);
    tick();

    // 64-bit: lui x1,0x80000 then slli x1,x1,63.
    send(1, 32'h800000B7, 6'b000010, 64'h0, 64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000, 0);
    send(1, 32'h03F09093, 6'b100000, 64'h0, 64'd63, 64'd63, 0);
    // Same word on 32-bit: shamt field is only 5 bits.
    send(0, 32'h03F09093, 6'b100000, 64'h0, 64'd31, 64'd31, 0);
    // beq x0,x0,-4 at 0x2000.
    send(0, 32'hFE000EE3, 6'b000100, 64'h2000, 64'hFFFFFFFC, 64'h00001FFC, 0);
    // jal x0,+0x800 at 0xFFFFFFF0, target wraps.
    send(0, 32'h0010006F, 6'b000001, 64'hFFFFFFF0, 64'h00000800, 64'h000007F0, 0);
    // sw with offset -8 at 0x10.
    send(0, 32'hFE002C23, 6'b001000, 64'h10, 64'hFFFFFFF8, 64'h00000008, 0);
    // Two bits set -> error, zero imm; zero select -> no error.
    send(0, 32'hFFF00093, 6'b010100, 64'h40, 64'h0, 64'h40, 1);
    send(0, 32'hFFF00093, 6'b000000, 64'h44, 64'h0, 64'h44, 0);
    repeat (3) tick();

    // Backpressure: two accepted, third stalled until release.
    out_ready32 = 1'b0;
    send(0, 32'h00100093, 6'b010000, 64'h0, 64'd1, 64'd1, 0);
    send(0, 32'h00200093, 6'b010000, 64'h0, 64'd2, 64'd2, 0);
    @(negedge clk);
    chk("bp_in_ready_low", {63'd0, in_ready32}, 64'd0);
    chk("bp_out_held",     {32'd0, imm32},      64'd1);
    tick();
    out_ready32 = 1'b1;
    send(0, 32'h00300093, 6'b010000, 64'h0, 64'd3, 64'd3, 0);
    repeat (4) tick();
    @(negedge clk);
    chk("bp_in_ready_back", {63'd0, in_ready32}, 64'd1);
    chk("bp_all_drained",   64'(q32.size()),     64'd0);
    tick();

    // Flush with both entries full and a beat offered.
    out_ready32 = 1'b0;
    send(0, 32'h00400093, 6'b010000, 64'h0, 64'd4, 64'd4, 0);
    send(0, 32'h00500093, 6'b010000, 64'h0, 64'd5, 64'd5, 0);
    instr32 = 32'h00600093; op32 = 6'b010000; pc32 = '0;
    in_valid32 = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid32 = 1'b0;
    q32.delete();
    @(negedge clk);
    chk("flush_out_valid", {63'd0, out_valid32}, 64'd0);
    chk("flush_in_ready",  {63'd0, in_ready32},  64'd1);
    tick();
    out_ready32 = 1'b1;
    // Flush with OUT empty: a beat accepted in the flush cycle is dropped.
    instr32 = 32'h00700093; in_valid32 = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid32 = 1'b0;
    @(negedge clk);
    chk("flush_accept_dropped", {63'd0, out_valid32}, 64'd0);
    repeat (4) tick();

    // Reset while full.
    out_ready32 = 1'b0;
    send(0, 32'hFFF00093, 6'b010000, 64'h100, 64'hFFFFFFFF, 64'hFF, 0);
    send(0, 32'hFE002C23, 6'b001000, 64'h10, 64'hFFFFFFF8, 64'h8, 0);
    rstn = 1'b0;
    tick();
    q32.delete();
    @(negedge clk);
    chk("rstfull_out_valid", {63'd0, out_valid32}, 64'd0);
    chk("rstfull_imm",       {32'd0, imm32},       64'd0);
    chk("rstfull_tgt",       {32'd0, tgt32},       64'd0);
    chk("rstfull_op_err",    {63'd0, err32},       64'd0);
    chk("rstfull_in_ready",  {63'd0, in_ready32},  64'd1);
    tick();
    rstn = 1'b1;
    out_ready32 = 1'b1;
    repeat (4) tick();
    chk("q32_empty", 64'(q32.size()), 64'd0);
    chk("q64_empty", 64'(q64.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Registered, parametrised immediate extender for the pipelined decode/execute boundary.
- Extracts the immediate directly from the full 32-bit instruction word, selected by the one-hot EXTOp.
- Sign-extends the immediate to XLEN and precomputes the PC-relative target, pc + imm.
- Uses a valid/ready handshake with a 2-entry skid buffer, so in_ready is driven from a register and backpressure never drops a beat. A flush clears every beat held in the block.

Parameters:
- XLEN, 32, datapath width. Legal values are 32 and 64.
- SHW, (XLEN==64 ? 6 : 5), shift-amount width. Derived from XLEN; do not override.

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  synchronous, active-low reset.
- flush  in  1  drops all held and incoming beats. Wins over every other event.
- in_valid  in  1  an input beat is offered.
- in_ready  out  1  the block can accept a beat. Driven from a register.
- instr  in  32  instruction word.
- ext_op  in  6  one-hot: [5] I_SHAMT, [4] I, [3] S, [2] B, [1] U, [0] J.
- pc  in  XLEN  PC of the instruction.
- out_valid  out  1  an output beat is present.
- out_ready  in  1  the consumer accepts the output beat.
- imm  out  XLEN  extended immediate.
- tgt  out  XLEN  pc + imm, mod 2^XLEN.
- op_err  out  1  ext_op was not one-hot. Zero is legal and is not an error.

Behaviour:
- Immediate extraction by ext_op. All fields come from instr. sext means sign-extend to XLEN.
  - I_SHAMT: zero-extend instr[20+SHW-1:20].
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: sext({instr[31:12], 12'b0}). For XLEN=64, instr[31] fills bits 63:32.
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - ext_op == 0: imm = 0, op_err = 0.
  - Two or more bits set: imm = 0, op_err = 1.
- tgt is always pc + imm, truncated to XLEN, whatever ext_op is. Overflow wraps silently.
- Storage and handshake:
  - Two entries, OUT and SKID. Each holds {imm, tgt, op_err} plus a valid bit.
  - Extraction and addition are combinational on the input side and are captured at acceptance.
  - Accept condition is in_valid && in_ready.
  - in_ready is registered and equals !SKID.valid.
- Next-state rules when flush = 0:
  - OUT drains when out_valid && out_ready.
  - OUT empty, or draining:
    - SKID valid: SKID moves to OUT. No accept can occur, because in_ready = 0.
    - SKID empty and accept: the new beat goes to OUT.
    - Otherwise: OUT.valid clears if it drained.
  - OUT full, not draining, and accept: the new beat goes to SKID. in_ready drops on the next cycle.
- Latency:
  - One cycle from accept to out_valid when OUT is empty.
  - Zero-bubble throughput of one beat per cycle while out_ready is held high.
- Ordering: strict FIFO. A SKID beat is always emitted before any later beat.
- flush = 1:
  - OUT.valid and SKID.valid clear at the next edge.
  - A beat accepted in the same cycle is discarded.
  - in_ready = 1 on the next cycle.
  - out_ready is ignored that cycle.
- Reset (rstn = 0 at the edge):
  - out_valid = 0, imm = 0, tgt = 0, op_err = 0.
  - SKID cleared, in_ready = 1.
  - Reset mid-transfer drops all held beats.
  - Reset wins over flush.
- Output data registers are held stable while out_valid && !out_ready.

Test Plan:
- Reset, then XLEN=32, instr=0xFFF00093 (addi x1,x0,-1), ext_op=I, pc=0x100 -> one cycle later out_valid=1, imm=0xFFFFFFFF, tgt=0x000000FF, op_err=0.
- XLEN=64, instr=0x800000B7 (lui x1,0x80000), ext_op=U, pc=0 -> imm=0xFFFFFFFF80000000. Then slli with instr[25:20]=0x3F, ext_op=I_SHAMT -> imm=63.
- Branch and jump offsets:
  - B-type with offset -4, pc=0x2000 -> imm=-4, tgt=0x1FFC.
  - J-type with offset +0x800, pc=0xFFFFFFF0 (XLEN=32) -> tgt=0x000007F0 (wrap).
- Backpressure: out_ready=0 while 3 beats are offered back-to-back -> the first two are accepted, in_ready=0 on cycle 3. Release out_ready -> beats emerge in order, no loss or duplication, in_ready returns to 1.
- With OUT and SKID full, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, and no flushed beat ever appears on the output.
- ext_op=6'b010100 -> imm=0, op_err=1. ext_op=0 -> imm=0, op_err=0. rstn=0 while full -> all outputs 0 next cycle.
